// File: rtl/pulse_stretch_pkg.sv
// Shared types and default stretch constants for pulse_stretch and its users.
package aegnn;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } stretch_state_e;

  localparam int unsigned DEF_HIGH_CYC = 4;
  localparam int unsigned DEF_GAP_CYC  = 1;
  localparam int unsigned DEF_PEND_W   = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretch_sat_counter.sv
// Saturating up/down counter with synchronous clear; sat is high at all-ones.
module sat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = (count == '1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches event pulses into HIGH_CYC-cycle levels separated by GAP_CYC low cycles, queueing overlaps.
// Define PULSE_STRETCH_OVF_EN to add the sticky ovf flag and the 8-bit drop_cnt output.
module pulse_stretch
  import aegnn::*;
#(
  parameter int unsigned HIGH_CYC = DEF_HIGH_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
  parameter int unsigned PEND_W   = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pulse_in,
  input  logic              clr,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
`ifdef PULSE_STRETCH_OVF_EN
  output logic              ovf,
  output logic [7:0]        drop_cnt,
`endif
  output logic              drop
);

  localparam int unsigned TW = $clog2(max_u(HIGH_CYC, GAP_CYC) + 1);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;

  stretch_state_e state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic           pend_inc, pend_dec, pend_sat, pend_nz, drop_nxt;

  assign pend_nz = (pend_cnt != '0);
  // In IDLE a pulse with an empty queue is consumed directly; with a non-empty
  // queue it is queued while the oldest pending event is replayed.
  assign pend_inc = pulse_in && ((state != IDLE) || pend_nz);
  assign drop_nxt = pend_inc && !pend_dec && pend_sat;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pend_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_in || pend_nz) begin
          state_nxt = HIGH;
          timer_nxt = HIGH_LOAD;
          pend_dec  = pend_nz;
        end
      end
      HIGH: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (GAP_CYC > 0) begin
          state_nxt = GAP;
          timer_nxt = GAP_LOAD;
        end else if (pend_nz) begin
          timer_nxt = HIGH_LOAD;
          pend_dec  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (pend_nz) begin
          state_nxt = HIGH;
          timer_nxt = HIGH_LOAD;
          pend_dec  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      timer <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
      drop  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      timer <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      level <= (state_nxt == HIGH);
      busy  <= (state_nxt != IDLE);
      drop  <= drop_nxt;
    end
  end

  sat_counter #(.W(PEND_W)) u_pend (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .clr   (clr),
    .count (pend_cnt),
    .sat   (pend_sat)
  );

`ifdef PULSE_STRETCH_OVF_EN
  logic drop_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (drop_nxt) begin
      ovf <= 1'b1;
    end
  end

  sat_counter #(.W(8)) u_drop_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (drop_nxt && !drop_sat),
    .dec   (1'b0),
    .clr   (clr),
    .count (drop_cnt),
    .sat   (drop_sat)
  );
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: three instances (default, GAP_CYC=0, PEND_W=2) against a timed scoreboard.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] pulse = '0;
  logic [2:0] clr = '0;
  logic [2:0] level, busy, drop;
  logic [2:0] pend0, pend1;
  logic [1:0] pend2;
`ifdef PULSE_STRETCH_OVF_EN
  logic [2:0] ovf;
  logic [7:0] dcnt0, dcnt1, dcnt2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // val/mask layout: [5]=level [4]=busy [3:1]=pend_cnt [0]=drop
  typedef struct {
    int         cyc;
    logic [5:0] val;
    logic [5:0] mask;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pulse_stretch #(.HIGH_CYC(4), .GAP_CYC(1), .PEND_W(3)) u_main (
    .clk(clk), .rstn(rstn), .pulse_in(pulse[0]), .clr(clr[0]),
    .level(level[0]), .busy(busy[0]), .pend_cnt(pend0),
`ifdef PULSE_STRETCH_OVF_EN
    .ovf(ovf[0]), .drop_cnt(dcnt0),
`endif
    .drop(drop[0])
  );

  pulse_stretch #(.HIGH_CYC(4), .GAP_CYC(0), .PEND_W(3)) u_g0 (
    .clk(clk), .rstn(rstn), .pulse_in(pulse[1]), .clr(clr[1]),
    .level(level[1]), .busy(busy[1]), .pend_cnt(pend1),
`ifdef PULSE_STRETCH_OVF_EN
    .ovf(ovf[1]), .drop_cnt(dcnt1),
`endif
    .drop(drop[1])
  );

  pulse_stretch #(.HIGH_CYC(4), .GAP_CYC(1), .PEND_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .pulse_in(pulse[2]), .clr(clr[2]),
    .level(level[2]), .busy(busy[2]), .pend_cnt(pend2),
`ifdef PULSE_STRETCH_OVF_EN
    .ovf(ovf[2]), .drop_cnt(dcnt2),
`endif
    .drop(drop[2])
  );

  // Negative arguments mark a field as don't-care.
  function automatic void push(input int c, input int l, input int b, input int p, input int d);
    exp_t e;
    e.cyc  = c;
    e.val  = '0;
    e.mask = '0;
    if (l >= 0) begin e.val[5] = l[0];        e.mask[5]   = 1'b1; end
    if (b >= 0) begin e.val[4] = b[0];        e.mask[4]   = 1'b1; end
    if (p >= 0) begin e.val[3:1] = p[2:0];    e.mask[3:1] = '1;   end
    if (d >= 0) begin e.val[0] = d[0];        e.mask[0]   = 1'b1; end
    sb.push_back(e);
  endfunction

  function automatic logic [5:0] obs(input int s);
    case (s)
      0:       return {level[0], busy[0], pend0, drop[0]};
      1:       return {level[1], busy[1], pend1, drop[1]};
      default: return {level[2], busy[2], 1'b0, pend2, drop[2]};
    endcase
  endfunction

  task automatic tick(input int s, input logic p, input logic c);
    pulse    = '0;
    clr      = '0;
    pulse[s] = p;
    clr[s]   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = obs(0);
    n_cmp++;
    if (o !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=%b", o, 6'b0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    exp_t e;
    logic [5:0] o;
    push(9, 0, 0, 0, 0);
    for (int c = 11; c <= 14; c++) push(c, 1, 1, 0, 0);
    push(15, 0, 1, 0, 0);
    push(16, 0, 0, 0, 0);
    push(17, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL single c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(0, c == 10, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] o;
    push(11, 1, 1, 0, 0);
    push(12, 1, 1, 1, 0);
    push(13, 1, 1, 2, 0);
    push(14, 1, 1, 2, 0);
    push(15, 0, 1, 2, 0);
    for (int c = 16; c <= 19; c++) push(c, 1, 1, 1, 0);
    push(20, 0, 1, 1, 0);
    for (int c = 21; c <= 24; c++) push(c, 1, 1, 0, 0);
    push(25, 0, 1, 0, 0);
    push(26, 0, 0, 0, 0);
    for (int c = 0; c < 28; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL back_to_back c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(0, c >= 10 && c <= 12, 1'b0);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [5:0] o;
    push(15, 0, 1, 2, 0);
    push(16, 1, 1, 2, 0);
    push(19, 1, 1, 2, 0);
    push(20, 0, 1, 2, 0);
    push(21, 1, 1, 1, 0);
    push(25, 0, 1, 1, 0);
    push(26, 1, 1, 0, 0);
    push(29, 1, 1, 0, 0);
    push(30, 0, 1, 0, 0);
    push(31, 0, 0, 0, 0);
    for (int c = 0; c < 33; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL simultaneous c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(0, (c >= 10 && c <= 12) || c == 15, 1'b0);
    end
  endtask

  task automatic test_clr();
    exp_t e;
    logic [5:0] o;
    push(6, 0, 0, 0, 0);
    push(7, 0, 0, 0, 0);
    push(11, 1, 1, 0, 0);
    push(12, 1, 1, 1, 0);
    for (int c = 13; c <= 18; c++) push(c, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL clr c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(0, c == 5 || (c >= 10 && c <= 12), c == 5 || c == 12);
    end
  endtask

  task automatic test_idle_entry();
    exp_t e;
    logic [5:0] o;
    push(14, 1, 1, 0, 0);
    push(15, 0, 1, 0, 0);
    push(16, 0, 0, 1, 0);
    push(17, 1, 1, 0, 0);
    push(20, 1, 1, 0, 0);
    push(21, 0, 1, 0, 0);
    push(22, 0, 0, 0, 0);
    for (int c = 0; c < 24; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL idle_entry c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(0, c == 10 || c == 15, 1'b0);
    end
  endtask

  task automatic test_gap_zero();
    exp_t e;
    logic [5:0] o;
    push(10, 0, 0, 0, 0);
    push(11, 1, 1, 0, 0);
    push(12, 1, 1, 0, 0);
    push(13, 1, 1, 1, 0);
    push(14, 1, 1, 1, 0);
    for (int c = 15; c <= 18; c++) push(c, 1, 1, 0, 0);
    push(19, 0, 0, 0, 0);
    push(20, 0, 0, 0, 0);
    for (int c = 0; c < 22; c++) begin
      o = obs(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL gap_zero c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(1, c == 10 || c == 12, 1'b0);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [5:0] o;
    push(11, 1, 1, 0, 0);
    push(12, 1, 1, 1, 0);
    push(13, 1, 1, 2, 0);
    push(14, 1, 1, 3, 0);
    push(15, 0, 1, 3, 1);
    push(16, 1, 1, 3, 0);
    push(17, 1, 1, 3, 1);
    push(18, 1, 1, 3, 0);
    for (int c = 0; c < 19; c++) begin
      o = obs(2);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL saturation c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(2, c >= 10 && c <= 16, 1'b0);
    end
`ifdef PULSE_STRETCH_OVF_EN
    n_cmp++;
    if (ovf[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky got=%b exp=1", ovf[2]);
    end
    n_cmp++;
    if (dcnt2 !== 8'd2) begin
      n_bad++;
      $display("FAIL drop_cnt got=%0d exp=2", dcnt2);
    end
`endif
    tick(2, 1'b1, 1'b1);
    o = obs(2);
    n_cmp++;
    if (o !== 6'b0) begin
      n_bad++;
      $display("FAIL sat_clr got=%b exp=%b", o, 6'b0);
    end
`ifdef PULSE_STRETCH_OVF_EN
    n_cmp++;
    if (ovf[2] !== 1'b0 || dcnt2 !== 8'd0) begin
      n_bad++;
      $display("FAIL ovf_clr got ovf=%b cnt=%0d exp ovf=0 cnt=0", ovf[2], dcnt2);
    end
`endif
    tick(2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [5:0] o;
    push(14, 1, 1, 3, 0);
    for (int c = 0; c <= 14; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL reset_mid_pre c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      if (c < 14) tick(0, c >= 10 && c <= 13, 1'b0);
    end
    pulse = '0;
    #2;
    rstn = 1'b0;
    #1;
    o = obs(0);
    n_cmp++;
    if (o !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async got=%b exp=%b", o, 6'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c += 4) push(c, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      o = obs(0);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL reset_mid_post c=%0d got=%b exp=%b mask=%b", c, o, e.val, e.mask);
        end
      end
      tick(0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_clr();
    test_idle_entry();
    test_gap_zero();
    test_saturation();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
